chunked_copy_ctrl: RTL and testbench

Sequencing controller for the wide bit-copy datapath (s = a, W bits). It accepts a W-bit word through a valid/ready handshake and copies U bits per clock into the output register. A full copy therefore takes W/U cycles and needs only a U-bit slice path instead of a fully unrolled W-bit one. The result is presented on a valid/ready output handshake; the block sits between the word producer and the consumer of `s`.

---
 rtl/chunked_copy_ctrl.sv | 87 ++++++++
 tb/tb_chunked_copy_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module : chunked_copy_ctrl
// Copies a W-bit word into the output register U bits per clock, framed by
// valid/ready handshakes on the producer and consumer sides.
// Rev    : 1.0
// ============================================================================
module chunked_copy_ctrl #(
  parameter  int W  = 256,
  parameter  int U  = 8,
  localparam int N  = W / U,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [W-1:0]  s,
  output logic          busy,
  output logic [CW-1:0] idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST_IDX = CW'(N - 1);

  state_t        r_state;
  logic [W-1:0]  r_src;
  logic [W-1:0]  r_s;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_src   <= a;
            r_s     <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Only the slice selected by the chunk counter is written this cycle.
          for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) r_s[k*U +: U] <= r_src[k*U +: U];
          end
          if (r_cnt == C_LAST_IDX) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (s_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign s_valid  = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);
  assign idx      = r_cnt;
  assign s        = r_s;

endmodule
`default_nettype wire

// File: tb/tb_chunked_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_chunked_copy_ctrl
// Self-checking bench for chunked_copy_ctrl (W=256/U=8 and W=8/U=8).
// Rev    : 1.0
// ============================================================================
module tb_chunked_copy_ctrl;

  logic         clk;
  logic         rst;
  logic         flush, in_valid, s_ready;
  logic [255:0] a;
  logic         in_ready, s_valid, busy;
  logic [255:0] s;
  logic [4:0]   idx;

  logic         flush_n1, in_valid_n1, s_ready_n1;
  logic [7:0]   a_n1;
  logic         in_ready_n1, s_valid_n1, busy_n1;
  logic [7:0]   s_n1;
  logic [0:0]   idx_n1;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];

  chunked_copy_ctrl #(.W(256), .U(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .s_valid(s_valid), .s_ready(s_ready), .s(s), .busy(busy), .idx(idx)
  );

  chunked_copy_ctrl #(.W(8), .U(8)) u_dut_n1 (
    .clk(clk), .rst(rst), .flush(flush_n1), .in_valid(in_valid_n1), .in_ready(in_ready_n1),
    .a(a_n1), .s_valid(s_valid_n1), .s_ready(s_ready_n1), .s(s_n1), .busy(busy_n1), .idx(idx_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one accepting edge and record it on the scoreboard.
  task automatic accept(input logic [255:0] word);
    in_valid = 1'b1;
    a        = word;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(word);
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (s !== '0) begin bad++; $display("FAIL reset_s: got %h want 0", s); end
    total++; if ({s_valid, in_ready, busy} !== 3'b010) begin bad++; $display("FAIL reset_flags: got v/r/b=%b want 010", {s_valid, in_ready, busy}); end
    total++; if (idx !== 5'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", idx); end
    total++; if ({s_valid_n1, in_ready_n1, busy_n1, s_n1} !== {3'b010, 8'h00}) begin bad++; $display("FAIL reset_n1: got %b want 01000000000", {s_valid_n1, in_ready_n1, busy_n1, s_n1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [255:0] e;
    s_ready = 1'b1;
    accept({4{64'h0123456789ABCDEF}});
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_accept: got ready=%b busy=%b want 0 1", in_ready, busy); end
    for (int i = 0; i < 32; i++) begin
      total++; if (idx !== 5'(i)) begin bad++; $display("FAIL basic_idx: got %0d want %0d", idx, i); end
      tick();
    end
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: got s_valid=%b want 1", s_valid); end
    e = exp_q.pop_front();
    total++; if (s !== e) begin bad++; $display("FAIL basic_data: got %h want %h", s, e); end
    tick();
    total++; if ({in_ready, s_valid, busy} !== 3'b100) begin bad++; $display("FAIL basic_idle: got r/v/b=%b want 100", {in_ready, s_valid, busy}); end
    total++; if (s !== e) begin bad++; $display("FAIL basic_hold: got %h want %h", s, e); end
  endtask

  task automatic test_isolation();
    logic [255:0] e;
    int c;
    s_ready = 1'b1;
    accept({256{1'b1}});
    a        = '0;
    in_valid = 1'b1;
    c = 0;
    while (!s_valid && c < 40) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL iso_ready: got %b want 0 at cycle %0d", in_ready, c); end
      tick();
      c++;
    end
    in_valid = 1'b0;
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL iso_timeout: got s_valid=%b want 1", s_valid); end
    e = exp_q.pop_front();
    total++; if (s !== e) begin bad++; $display("FAIL iso_data: got %h want %h", s, e); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [255:0] e;
    int c;
    s_ready = 1'b0;
    accept(rand_word());
    c = 0;
    while (!s_valid && c < 40) begin tick(); c++; end
    total++; if (c !== 32) begin bad++; $display("FAIL bp_latency: got %0d cycles want 32", c); end
    for (int i = 0; i < 5; i++) begin
      total++; if ({s_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_flags: got v/r=%b want 10", {s_valid, in_ready}); end
      total++; if (s !== exp_q[0]) begin bad++; $display("FAIL bp_data: got %h want %h", s, exp_q[0]); end
      tick();
    end
    s_ready = 1'b1;
    e = exp_q.pop_front();
    tick();
    total++; if ({in_ready, s_valid} !== 2'b10) begin bad++; $display("FAIL bp_release: got r/v=%b want 10", {in_ready, s_valid}); end
    total++; if (s !== e) begin bad++; $display("FAIL bp_retain: got %h want %h", s, e); end
  endtask

  task automatic test_flush();
    logic [255:0] e;
    int c;
    s_ready = 1'b1;
    accept(rand_word());
    c = 0;
    while (idx !== 5'd10 && c < 40) begin tick(); c++; end
    total++; if (idx !== 5'd10) begin bad++; $display("FAIL flush_reach: got idx=%0d want 10", idx); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp_q.pop_front());
    total++; if (s !== '0) begin bad++; $display("FAIL flush_s: got %h want 0", s); end
    total++; if ({in_ready, s_valid, busy} !== 3'b100) begin bad++; $display("FAIL flush_flags: got r/v/b=%b want 100", {in_ready, s_valid, busy}); end
    // accept and flush together: the word is dropped
    in_valid = 1'b1;
    a        = rand_word();
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    total++; if ({in_ready, busy} !== 2'b10) begin bad++; $display("FAIL flush_accept: got r/b=%b want 10", {in_ready, busy}); end
    accept(rand_word());
    c = 0;
    while (!s_valid && c < 40) begin tick(); c++; end
    total++; if (c !== 32) begin bad++; $display("FAIL flush_relatency: got %0d cycles want 32", c); end
    e = exp_q.pop_front();
    total++; if (s !== e) begin bad++; $display("FAIL flush_redata: got %h want %h", s, e); end
    tick();
  endtask

  task automatic test_async_rst();
    int c;
    s_ready = 1'b1;
    accept(rand_word());
    c = 0;
    while (idx !== 5'd5 && c < 40) begin tick(); c++; end
    void'(exp_q.pop_front());
    #2;
    rst = 1'b1;
    #1;
    total++; if (s !== '0) begin bad++; $display("FAIL arst_s: got %h want 0", s); end
    total++; if ({s_valid, in_ready, busy, idx} !== {3'b010, 5'd0}) begin bad++; $display("FAIL arst_flags: got v/r/b/idx=%b want 01000000", {s_valid, in_ready, busy, idx}); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_n1();
    s_ready_n1  = 1'b1;
    in_valid_n1 = 1'b1;
    a_n1        = 8'hA5;
    tick();
    in_valid_n1 = 1'b0;
    a_n1        = 8'h00;
    total++; if ({in_ready_n1, s_valid_n1, busy_n1} !== 3'b001) begin bad++; $display("FAIL n1_run: got r/v/b=%b want 001", {in_ready_n1, s_valid_n1, busy_n1}); end
    tick();
    total++; if (s_valid_n1 !== 1'b1 || s_n1 !== 8'hA5) begin bad++; $display("FAIL n1_done: got v=%b s=%h want 1 a5", s_valid_n1, s_n1); end
    tick();
    total++; if (in_ready_n1 !== 1'b1 || s_n1 !== 8'hA5) begin bad++; $display("FAIL n1_idle: got r=%b s=%h want 1 a5", in_ready_n1, s_n1); end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; s_ready = 1'b0; a = '0;
    flush_n1 = 1'b0; in_valid_n1 = 1'b0; s_ready_n1 = 1'b0; a_n1 = '0;
    test_reset();
    test_basic();
    test_isolation();
    test_backpressure();
    test_flush();
    test_async_rst();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
